// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - multi-lane pipeline stage register with valid/ready handshake
//
// Purpose:
//   Generic stage register that sits between two pipeline stages of the
//   dual-issue core. It holds whole issue bundles (per-lane valids plus
//   payload). Back-pressure comes from the downstream out_ready. Bundles
//   whose lane valids are all zero are bubbles and are dropped on entry.
//
// Configuration macro:
//   PIPE_SKID_EN  - when defined, adds a skid entry behind the main entry.
//                   in_ready is then taken from registered state only, and
//                   occupancy ranges 0..2. When undefined, only the main
//                   entry exists, in_ready = !main_valid | out_ready, and
//                   occupancy ranges 0..1.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   flush           in   synchronous kill of all held bundles
//   in_valid        in   upstream bundle present
//   in_lane_valid   in   per-lane valid of the incoming bundle
//   in_data         in   incoming payload, lane i at [i*DATA_W +: DATA_W]
//   in_ready        out  block can accept a bundle this cycle
//   out_valid       out  bundle presented downstream
//   out_lane_valid  out  per-lane valid of the presented bundle
//   out_data        out  presented payload, zero when out_valid is 0
//   out_ready       in   downstream consumes the bundle this cycle
//   occupancy       out  number of held bundles
module pipe_stage_buf #(
  parameter int LANES  = 2,
  parameter int DATA_W = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  localparam int W = LANES * DATA_W;

  logic             main_valid;
  logic [LANES-1:0] main_lv;
  logic [W-1:0]     main_data;

  logic accept;
  logic consume;

  // Bubbles (no lane valid) are never stored; flush also blocks the
  // same-cycle input even when in_ready is high.
  assign accept  = in_valid & in_ready & (|in_lane_valid) & ~flush;
  assign consume = main_valid & out_ready;

  assign out_valid      = main_valid;
  assign out_lane_valid = main_valid ? main_lv   : '0;
  assign out_data       = main_valid ? main_data : '0;

`ifdef PIPE_SKID_EN

  logic             skid_valid;
  logic [LANES-1:0] skid_lv;
  logic [W-1:0]     skid_data;

  // Ready depends on state only, so there is no path from out_ready.
  assign in_ready  = ~skid_valid;
  // The skid entry is only ever filled while main is valid.
  assign occupancy = skid_valid ? 2'd2 : {1'b0, main_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_lv    <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_lv    <= '0;
      skid_data  <= '0;
    end else if (!main_valid) begin
      // EMPTY
      if (accept) begin
        main_valid <= 1'b1;
        main_lv    <= in_lane_valid;
        main_data  <= in_data;
      end
    end else if (skid_valid) begin
      // FULL: in_ready is low, so only a consume can move state.
      if (consume) begin
        main_lv    <= skid_lv;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_lv    <= '0;
        skid_data  <= '0;
      end
    end else begin
      // ONE
      if (accept && consume) begin
        main_lv   <= in_lane_valid;
        main_data <= in_data;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_lv    <= in_lane_valid;
        skid_data  <= in_data;
      end else if (consume) begin
        main_valid <= 1'b0;
        main_lv    <= '0;
        main_data  <= '0;
      end
    end
  end

`else

  // Without a skid entry the stage can take a new bundle only when main is
  // empty or is being drained in the same cycle.
  assign in_ready  = ~main_valid | out_ready;
  assign occupancy = {1'b0, main_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_data  <= '0;
    end else if (accept) begin
      // Covers both EMPTY fill and the ONE overwrite on consume.
      main_valid <= 1'b1;
      main_lv    <= in_lane_valid;
      main_data  <= in_data;
    end else if (consume) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_data  <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf
//
// Purpose:
//   Drives directed bundles into pipe_stage_buf (LANES=2, DATA_W=128).
//   Each bundle the stage should accept is pushed into an expected queue.
//   A separate monitor pops and compares whenever a bundle is consumed
//   downstream. Handshake, occupancy and zero-forcing are checked against
//   a small occupancy model. Works with or without PIPE_SKID_EN.
module tb_pipe_stage_buf;

  localparam int LANES  = 2;
  localparam int DATA_W = 128;
  localparam int W      = LANES * DATA_W;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [LANES-1:0] in_lane_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [LANES-1:0] out_lane_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  pipe_stage_buf #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_lane_valid  (in_lane_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_lane_valid (out_lane_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] lv;
    logic [W-1:0]     data;
  } bundle_t;

  bundle_t exp_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      occ   = 0;

  localparam logic [W-1:0] A  = {128'hA1A1_0001, 128'hA0A0_0000};
  localparam logic [W-1:0] B  = {128'hB1B1_0011, 128'hB0B0_0010};
  localparam logic [W-1:0] C  = {128'hC1C1_0021, 128'hC0C0_0020};
  localparam logic [W-1:0] D  = {128'hD1D1_0031, 128'hD0D0_0030};
  localparam logic [W-1:0] E  = {128'hE1E1_0041, 128'hE0E0_0040};
  localparam logic [W-1:0] F  = {128'hF1F1_0051, 128'hF0F0_0050};
  localparam logic [W-1:0] G  = {128'h6161_0061, 128'h6060_0060};
  localparam logic [W-1:0] DE = {128'h0, 128'hDEAD};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a consumed bundle must be the oldest expected one. During
  // flush the presented bundle is discarded downstream, so it is skipped.
  always @(negedge clk) begin
    if (rst === 1'b1 && flush === 1'b0) begin
      if (out_valid === 1'b1) begin
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got data %h with empty scoreboard", out_data);
          end else begin
            chk("out_lane_valid", W'(out_lane_valid), W'(exp_q[0].lv));
            chk("out_data", out_data, exp_q[0].data);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_lane_valid_zero", W'(out_lane_valid), '0);
        chk("idle_data_zero", out_data, '0);
      end
    end
  end

  // One clock of stimulus. Called just after a rising edge.
  task automatic cycle(input logic iv, input logic [LANES-1:0] lv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    logic exp_rdy;
    logic acc;
    logic cons;
    bundle_t b;
    in_valid      = iv;
    in_lane_valid = lv;
    in_data       = d;
    out_ready     = ordy;
    flush         = fl;
    @(negedge clk);
    exp_rdy = SKID ? (occ < 2) : (occ == 0 || ordy);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    chk("occupancy", W'(occupancy), W'(occ));
    chk("out_valid", W'(out_valid), W'(occ > 0));
    acc  = !fl && iv && exp_rdy && (lv != '0);
    cons = (occ > 0) && ordy;
    if (acc) begin
      b.lv   = lv;
      b.data = d;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      occ = 0;
    end else begin
      occ = occ + int'(acc) - int'(cons);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_lane_valid = '0;
    in_data       = '0;
    out_ready     = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_lv", W'(out_lane_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full throughput
    cycle(1'b1, 2'b11, A, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, B, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, C, 1'b1, 1'b0);
    idle(2);

    // Back-pressure: skid build holds A and B; plain build replaces A with C
    cycle(1'b1, 2'b11, A, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, B, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, B, 1'b0, 1'b0);
    chk("held_data_A", out_data, A);
    cycle(1'b1, 2'b11, C, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, D, 1'b1, 1'b0);
    idle(3);

    // Bubble filter
    cycle(1'b1, 2'b00, DE, 1'b1, 1'b0);
    chk("bubble_occupancy", W'(occupancy), '0);
    cycle(1'b1, 2'b01, E, 1'b1, 1'b0);
    idle(2);

    // Fill, bubble while full, then flush with a simultaneous input
    cycle(1'b1, 2'b11, A, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, B, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, DE, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, C, 1'b0, 1'b1);
    chk("flush_out_data", out_data, '0);
    chk("flush_occupancy", W'(occupancy), '0);
    // Flush from EMPTY with in_ready high still rejects the input
    cycle(1'b1, 2'b11, E, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset between edges while in ONE
    cycle(1'b1, 2'b11, F, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_occupancy", W'(occupancy), '0);
    chk("arst_in_ready", W'(in_ready), W'(1'b1));
    exp_q.delete();
    occ = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 2'b11, G, 1'b1, 1'b0);
    chk("post_rst_latency", out_data, G);
    idle(2);

    // Mixed handshake pattern
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rdy_pat;
      logic [7:0] vld_pat;
      logic [W-1:0] d;
      rdy_pat = 8'b1011_0110;
      vld_pat = 8'b1110_1101;
      d = W'(32'h1000 + i);
      cycle(vld_pat[i], 2'(i % 3 + 1), d, rdy_pat[i], 1'b0);
    end
    idle(4);

    chk("drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised multi-lane pipeline stage register with a valid/ready handshake, an optional skid entry, flush, and empty-bundle filtering. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) of the dual-issue core. It replaces the fixed-field, stall-vector-driven stage registers with one generic block, so back-pressure comes from the downstream `out_ready` instead of a global stall bus.

## Interface
Parameters:
- `LANES`, default 2: number of issue lanes carried per bundle.
- `DATA_W`, default 128: payload bits per lane (wd, wreg, wdata, pc, aluop, addr, etc., packed by the instantiating stage).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of all held bundles.
- `in_valid`  in  1  upstream bundle present.
- `in_lane_valid`  in  LANES  per-lane instruction valid.
- `in_data`  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- `in_ready`  out  1  block can accept a bundle this cycle.
- `out_valid`  out  1  bundle presented downstream.
- `out_lane_valid`  out  LANES  per-lane valid of the presented bundle.
- `out_data`  out  LANES*DATA_W  presented payload; all-zero when `out_valid`=0.
- `out_ready`  in  1  downstream consumes the bundle this cycle.
- `occupancy`  out  2  held bundles, 0..2.

## Operation
- Accept = `in_valid` & `in_ready` & `|in_lane_valid`. A bundle with all lane valids 0 is a bubble: it is dropped, never stored, and never counted.
- Consume = `out_valid` & `out_ready`.
- Storage is a main entry that drives the outputs and a skid entry (skid present only with `PIPE_SKID_EN`). Each entry holds a valid bit, the lane valids and the payload.
- State by occupancy:
  - EMPTY(0): accept -> ONE, bundle written to main.
  - ONE(1): accept & consume -> ONE, main overwritten with the new bundle. Accept & !consume -> FULL, bundle written to skid. !accept & consume -> EMPTY. Otherwise hold.
  - FULL(2): no accept is possible. Consume -> ONE, skid moves to main and skid clears. Otherwise hold.
- Ordering is strictly FIFO; a bundle is never duplicated or lost except by flush.
- `flush` has priority over everything: both entries are cleared (valid, lane valids and payload set to 0), `occupancy` goes to 0, and the same-cycle input is not accepted even when `in_ready`=1. The same-cycle output is still visible that cycle, but downstream must also honour flush.
- `out_lane_valid` and `out_data` are forced to 0 whenever the main entry is invalid.

## Timing
- Reset (`rst`=0, asynchronous): `out_valid`=0, `out_lane_valid`=0, `out_data`=0, `occupancy`=0, skid cleared. `in_ready`=1 during and after reset.
- Latency: an accepted bundle appears on `out_*` the cycle after the accepting edge. Throughput is 1 bundle/cycle while `out_ready`=1.
- With `PIPE_SKID_EN`, `in_ready` = !skid_valid. It is registered and has no combinational path from `out_ready`.
- Removing reset mid-operation returns the block to EMPTY. No partial bundle survives.
- A bubble arriving while the block is FULL is ignored, because `in_ready`=0.

## Configuration
- `PIPE_SKID_EN` defined: the skid entry is present and `occupancy` ranges 0..2. `in_ready` depends only on state, which breaks the ready timing path across stages.
- `PIPE_SKID_EN` undefined: main entry only, and `occupancy` ranges 0..1 with bit 1 tied to 0. `in_ready` = !main_valid | `out_ready` (combinational). Transitions are EMPTY/ONE only, and accept & consume in ONE overwrites main.

## Test plan
- Reset then stream: LANES=2, `out_ready`=1, bundles A, B, C with `in_lane_valid`=2'b11 on consecutive cycles -> `out_data` shows A, B, C one cycle later each; `occupancy` stays 1.
- Back-pressure (skid build): accept A; `out_ready`=0 and send B -> `occupancy`=2, `in_ready`=0, `out_data`=A held. Raise `out_ready` -> A consumed, then B consumed; C is accepted only after `in_ready` returns to 1.
- Bubble filter: `in_valid`=1, `in_lane_valid`=2'b00, payload 0xDEAD -> `out_valid` stays 0 and `occupancy` stays 0. `in_lane_valid`=2'b01 -> `out_lane_valid`=2'b01.
- Flush with simultaneous input: block FULL (A, B), `flush`=1 and `in_valid`=1 with C -> next cycle `out_valid`=0, `out_data`=0, `occupancy`=0; C is never output.
- Async reset mid-stream: assert `rst`=0 between edges while in ONE -> outputs go to 0 immediately, without waiting for a clock edge; after release, the first accepted bundle appears with 1-cycle latency.
- Macro off: rebuild without `PIPE_SKID_EN`, hold `out_ready`=0 with A held -> `in_ready`=0 and `occupancy` never exceeds 1. Toggle `out_ready`=1 with B valid -> B replaces A in the same cycle A is consumed.
